// File: rtl/rob_pkg.sv
// Shared ROB types: issue packet, uop encoding, entry status and the FU->ROB writeback record.
package rob_pkg;

    localparam int ROB_ENTRIES = 128;
    localparam int ROB_PTR_W   = $clog2(ROB_ENTRIES);

    typedef enum logic [1:0] {
        READY     = 2'd0,
        DONE      = 2'd1,
        EXCEPTION = 2'd2
    } status_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [10:0] imm;
    } uop_insn;

    typedef struct packed {
        logic                 valid;
        uop_insn              uop;
        logic [ROB_PTR_W-1:0] ptr;
    } rob_issue;

    typedef struct packed {
        logic                 valid;
        logic [ROB_PTR_W-1:0] ptr;
        status_t              status;
    } rob_wb;

    function automatic status_t wb_status(input logic exc);
        return exc ? EXCEPTION : DONE;
    endfunction

endpackage

// File: rtl/rob_issue_fifo.sv
// In-order synchronous FIFO holding {uop, ptr} entries between ROB issue and FU dispatch.
module rob_issue_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 40
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic                     push_in,
    input  logic [W-1:0]             data_in,
    input  logic                     pop_in,
    output logic [W-1:0]             data_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // count[AW] set means exactly DEPTH entries: a full FIFO refuses pushes even alongside a pop
    assign w_push = push_in && !flush_in && !r_count[AW];
    assign w_pop  = pop_in && !flush_in && (r_count != '0);

    // Storage array; no reset needed since only entries below count are ever observed
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_tail] <= data_in;
        end
    end

    // Head/tail pointers and occupancy
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out  = r_mem[r_head];
    assign count_out = r_count;

endmodule

// File: rtl/rob_issue_receiver.sv
// ROB issue consumer: buffers issued uops, dispatches them in order to one FU, returns writebacks.
// Optional zero-latency issue-to-dispatch path enabled by defining ISSUE_BYPASS_EN.
module rob_issue_receiver
    import rob_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 4,
    parameter int PTR_W        = $clog2(ROB_ENTRIES)
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              flush_in,
    input  rob_issue                          issue_in,
    output logic                              issue_ready_out,
    output logic                              fu_valid_out,
    output uop_insn                           fu_uop_out,
    output logic [PTR_W-1:0]                  fu_ptr_out,
    input  logic                              fu_ready_in,
    input  logic                              fu_done_in,
    input  logic [PTR_W-1:0]                  fu_done_ptr_in,
    input  logic                              fu_exc_in,
    output logic                              wb_valid_out,
    output logic [PTR_W-1:0]                  wb_ptr_out,
    output status_t                           wb_status_out,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_out,
    output logic                              err_out
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int EW    = $bits(uop_insn) + PTR_W;

    logic [CNT_W-1:0] w_count;
    logic [EW-1:0]    w_head;
    logic             w_issue_ready;
    logic             w_room;
    logic             w_bypass;
    logic             w_fu_valid;
    uop_insn          w_fu_uop;
    logic [PTR_W-1:0] w_fu_ptr;
    logic             w_dispatch;
    logic             w_push;
    logic             w_pop;
    logic             w_done_ok;
    logic             w_done_err;
    logic [IF_W-1:0]  r_inflight;
    rob_wb            r_wb;
    logic             r_err;

    rob_issue_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush_in  (flush_in),
        .push_in   (w_push),
        .data_in   ({issue_in.uop, issue_in.ptr}),
        .pop_in    (w_pop),
        .data_out  (w_head),
        .count_out (w_count)
    );

    assign w_issue_ready = (w_count < CNT_W'(DEPTH));
    assign w_room        = (r_inflight < IF_W'(MAX_INFLIGHT));

    // Dispatch source select; outputs are zeroed when nothing is presented and gated during flush
    always_comb begin
        w_bypass   = 1'b0;
        w_fu_valid = 1'b0;
        w_fu_uop   = '0;
        w_fu_ptr   = '0;
`ifdef ISSUE_BYPASS_EN
        w_bypass = (w_count == '0) && w_room && !flush_in;
`endif
        if (flush_in) begin
            w_fu_valid = 1'b0;
        end else if (w_bypass) begin
            w_fu_valid = issue_in.valid;
            w_fu_uop   = issue_in.valid ? issue_in.uop : '0;
            w_fu_ptr   = issue_in.valid ? issue_in.ptr : '0;
        end else if ((w_count != '0) && w_room) begin
            w_fu_valid = 1'b1;
            w_fu_uop   = w_head[EW-1:PTR_W];
            w_fu_ptr   = w_head[PTR_W-1:0];
        end else begin
            w_fu_valid = 1'b0;
        end
    end

    assign w_dispatch = w_fu_valid && fu_ready_in;
    assign w_push     = issue_in.valid && w_issue_ready && !flush_in && !(w_bypass && w_dispatch);
    assign w_pop      = w_dispatch && !w_bypass;
    assign w_done_ok  = fu_done_in && !flush_in && (r_inflight != '0);
    assign w_done_err = fu_done_in && !flush_in && (r_inflight == '0);

    // In-flight uop count between dispatch and completion
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            r_inflight <= '0;
        end else begin
            case ({w_dispatch, w_done_ok})
                2'b10:   r_inflight <= r_inflight + IF_W'(1);
                2'b01:   r_inflight <= r_inflight - IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Writeback register: pulses valid one cycle after an accepted completion, fields hold otherwise
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wb.valid  <= 1'b0;
            r_wb.ptr    <= '0;
            r_wb.status <= READY;
        end else if (flush_in) begin
            r_wb.valid  <= 1'b0;
        end else begin
            r_wb.valid <= w_done_ok;
            if (w_done_ok) begin
                r_wb.ptr    <= fu_done_ptr_in;
                r_wb.status <= wb_status(fu_exc_in);
            end
        end
    end

    // Sticky error on a completion with nothing in flight; survives flush
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_err <= 1'b0;
        end else if (w_done_err) begin
            r_err <= 1'b1;
        end
    end

    assign issue_ready_out = w_issue_ready;
    assign fu_valid_out    = w_fu_valid;
    assign fu_uop_out      = w_fu_uop;
    assign fu_ptr_out      = w_fu_ptr;
    assign wb_valid_out    = r_wb.valid;
    assign wb_ptr_out      = r_wb.ptr;
    assign wb_status_out   = r_wb.status;
    assign inflight_out    = r_inflight;
    assign err_out         = r_err;

endmodule
